// File: rtl/n_way_race_ctrl.sv
// Race controller: launches N_WAY workers, awaits the selected (or first) finisher,
// aborts the rest, then reports one result record over a valid/ready handshake.
module n_way_race_ctrl #(
  parameter int N_WAY   = 4,
  parameter int RES_W   = 16,
  parameter int TIMEOUT = 1024,
  parameter int IDW     = $clog2(N_WAY)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start_valid,
  output logic                   start_ready,
  input  logic                   await_any,
  input  logic [IDW-1:0]         await_idx,
  output logic [N_WAY-1:0]       launch,
  input  logic [N_WAY-1:0]       started,
  input  logic [N_WAY-1:0]       done,
  input  logic [N_WAY*RES_W-1:0] result,
  output logic [N_WAY-1:0]       kill,
  input  logic [N_WAY-1:0]       kill_ack,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [IDW-1:0]         out_winner,
  output logic [RES_W-1:0]       out_result,
  output logic [N_WAY-1:0]       out_done_mask,
  output logic [N_WAY-1:0]       out_kill_mask,
  output logic [1:0]             out_status,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT_START, S_AWAIT, S_KILL, S_REPORT
  } state_t;

  localparam logic [1:0] ST_OK      = 2'd0;
  localparam logic [1:0] ST_TIMEOUT = 2'd1;
  localparam logic [1:0] ST_BAD_IDX = 2'd2;

  localparam int              CNT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] WD_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

  state_t               state_q;
  logic                 await_any_q;
  logic [IDW-1:0]       await_idx_q;
  logic [N_WAY-1:0]     launch_q;
  logic [N_WAY-1:0]     kill_q;
  logic                 launched_q;
  logic [N_WAY-1:0]     started_seen_q, started_seen_d;
  logic [N_WAY-1:0]     done_seen_q,    done_seen_d;
  logic [N_WAY-1:0]     killed_seen_q,  killed_seen_d;
  logic                 have_win_q;
  logic [IDW-1:0]       win_q;
  logic [RES_W-1:0]     res_q;
  logic [1:0]           status_q;
  logic                 out_valid_q;
  logic [CNT_W-1:0]     wd_q;

  logic                 track;
  logic [N_WAY-1:0]     started_all;
  logic [N_WAY-1:0]     target_mask;
  logic [N_WAY-1:0]     qual;
  logic                 qual_hit;
  logic [IDW-1:0]       qual_idx;
  logic [RES_W-1:0]     qual_res;
  logic [N_WAY-1:0]     kill_next;
  logic                 wd_expire;

  function automatic logic [IDW-1:0] lowest_idx(input logic [N_WAY-1:0] v);
    lowest_idx = '0;
    for (int i = N_WAY - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = IDW'(i);
    end
  endfunction

  always_comb begin
    track       = (state_q == S_WAIT_START) || (state_q == S_AWAIT) || (state_q == S_KILL);
    started_all = started_seen_q | started | done;
    target_mask = '0;
    for (int i = 0; i < N_WAY; i++) begin
      target_mask[i] = (await_idx_q == IDW'(i));
    end

    // A worker already killed can no longer be credited with a normal finish.
    started_seen_d = track ? started_all : started_seen_q;
    done_seen_d    = track ? (done_seen_q | (done & ~killed_seen_q)) : done_seen_q;
    killed_seen_d  = (state_q == S_KILL) ? (killed_seen_q | (kill_ack & kill_q & ~done))
                                         : killed_seen_q;

    qual     = await_any_q ? done : (done & target_mask);
    qual_hit = (|qual) && !have_win_q &&
               ((state_q == S_WAIT_START) || (state_q == S_AWAIT));
    qual_idx = lowest_idx(qual);
    qual_res = '0;
    for (int i = 0; i < N_WAY; i++) begin
      if (qual_idx == IDW'(i)) qual_res = result[i*RES_W +: RES_W];
    end

    kill_next = ~done_seen_d & ~killed_seen_d & (started_seen_d | {N_WAY{launched_q}});
    wd_expire = (TIMEOUT != 0) && (wd_q == WD_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      await_any_q    <= 1'b0;
      await_idx_q    <= '0;
      launch_q       <= '0;
      kill_q         <= '0;
      launched_q     <= 1'b0;
      started_seen_q <= '0;
      done_seen_q    <= '0;
      killed_seen_q  <= '0;
      have_win_q     <= 1'b0;
      win_q          <= '0;
      res_q          <= '0;
      status_q       <= ST_OK;
      out_valid_q    <= 1'b0;
      wd_q           <= '0;
    end else begin
      started_seen_q <= started_seen_d;
      done_seen_q    <= done_seen_d;
      killed_seen_q  <= killed_seen_d;
      launch_q       <= '0;

      case (state_q)
        S_IDLE: begin
          if (start_valid) begin
            await_any_q    <= await_any;
            await_idx_q    <= await_idx;
            started_seen_q <= '0;
            done_seen_q    <= '0;
            killed_seen_q  <= '0;
            have_win_q     <= 1'b0;
            win_q          <= '0;
            res_q          <= '0;
            if (!await_any && (int'(await_idx) >= N_WAY)) begin
              launched_q  <= 1'b0;
              status_q    <= ST_BAD_IDX;
              out_valid_q <= 1'b1;
              state_q     <= S_REPORT;
            end else begin
              launched_q <= 1'b1;
              status_q   <= ST_OK;
              launch_q   <= '1;
              state_q    <= S_LAUNCH;
            end
          end
        end

        S_LAUNCH: begin
          wd_q    <= '0;
          state_q <= S_WAIT_START;
        end

        S_WAIT_START: begin
          // An early qualifying finish is remembered and honoured on AWAIT entry.
          if (qual_hit) begin
            have_win_q <= 1'b1;
            win_q      <= qual_idx;
            res_q      <= qual_res;
          end
          if (&started_all) begin
            wd_q    <= '0;
            state_q <= S_AWAIT;
          end else if (wd_expire) begin
            status_q <= ST_TIMEOUT;
            win_q    <= '0;
            res_q    <= '0;
            kill_q   <= kill_next;
            state_q  <= S_KILL;
          end else begin
            wd_q <= wd_q + CNT_W'(1);
          end
        end

        S_AWAIT: begin
          if (have_win_q || qual_hit) begin
            if (qual_hit) begin
              have_win_q <= 1'b1;
              win_q      <= qual_idx;
              res_q      <= qual_res;
            end
            kill_q  <= kill_next;
            state_q <= S_KILL;
          end else if (wd_expire) begin
            status_q <= ST_TIMEOUT;
            win_q    <= '0;
            res_q    <= '0;
            kill_q   <= kill_next;
            state_q  <= S_KILL;
          end else begin
            wd_q <= wd_q + CNT_W'(1);
          end
        end

        S_KILL: begin
          if (&(done_seen_d | killed_seen_d)) begin
            kill_q      <= '0;
            out_valid_q <= 1'b1;
            state_q     <= S_REPORT;
          end else begin
            kill_q <= kill_next;
          end
        end

        S_REPORT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign start_ready   = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign launch        = launch_q;
  assign kill          = kill_q;
  assign out_valid     = out_valid_q;
  assign out_winner    = win_q;
  assign out_result    = res_q;
  assign out_done_mask = done_seen_q;
  assign out_kill_mask = killed_seen_q;
  assign out_status    = status_q;

endmodule
